// File: rtl/piso_shift_cell.sv
// Parallel-in serial-out shift cell with a valid/ready load handshake.
// A new word can be accepted on the last bit of the current frame, so frames can run back-to-back.
module piso_shift_cell #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             CP,
    input  logic             CDN,
    input  logic [WIDTH-1:0] PD,
    input  logic             LD_VALID,
    output logic             LD_READY,
    input  logic             EN,
    output logic             Q,
    output logic             Q_VALID,
    output logic             Q_LAST,
    output logic             BUSY
);

    localparam int CNT_W   = $clog2(WIDTH);
    localparam int OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [CNT_W-1:0]   r_cnt;

    logic w_shift;
    logic w_cnt_zero;
    logic w_accept;

    function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] v);
        if (MSB_FIRST != 0)
            return {v[WIDTH-2:0], 1'b0};
        else
            return {1'b0, v[WIDTH-1:1]};
    endfunction

    assign w_shift    = (r_state == SHIFT);
    assign w_cnt_zero = (r_cnt == '0);
    // Ready on the final enabled bit as well as in IDLE, giving zero-bubble reloads.
    assign LD_READY   = !w_shift || (w_cnt_zero && EN);
    assign w_accept   = LD_VALID && LD_READY;

    assign Q       = w_shift && r_shreg[OUT_IDX];
    assign Q_VALID = w_shift;
    assign Q_LAST  = w_shift && w_cnt_zero;
    assign BUSY    = w_shift;

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= SHIFT;
            r_shreg <= PD;
            r_cnt   <= CNT_W'(WIDTH - 1);
        end else if (w_shift && EN) begin
            if (!w_cnt_zero) begin
                r_shreg <= f_shift(r_shreg);
                r_cnt   <= r_cnt - CNT_W'(1);
            end else begin
                r_state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_piso_shift_cell.sv
// Directed bench for piso_shift_cell: one MSB-first and one LSB-first instance on shared inputs.
module tb_piso_shift_cell;

    logic       CP = 1'b0;
    logic       CDN;
    logic [7:0] PD;
    logic       LD_VALID;
    logic       EN;

    logic rdy_m, q_m, qv_m, ql_m, busy_m;
    logic rdy_l, q_l, qv_l, ql_l, busy_l;

    int total = 0;
    int bad   = 0;

    piso_shift_cell #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .CP(CP), .CDN(CDN), .PD(PD), .LD_VALID(LD_VALID), .LD_READY(rdy_m),
        .EN(EN), .Q(q_m), .Q_VALID(qv_m), .Q_LAST(ql_m), .BUSY(busy_m)
    );

    piso_shift_cell #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .CP(CP), .CDN(CDN), .PD(PD), .LD_VALID(LD_VALID), .LD_READY(rdy_l),
        .EN(EN), .Q(q_l), .Q_VALID(qv_l), .Q_LAST(ql_l), .BUSY(busy_l)
    );

    always #5 CP = ~CP;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Walks n frame cycles with EN=1 and no load; stream[n-1] is the first expected bit.
    task automatic play(input string tag, input logic [15:0] stream, input int n, input bit lsb);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_q%0d", tag, i),  lsb ? q_l  : q_m,  stream[n-1-i]);
            chk($sformatf("%s_qv%0d", tag, i), lsb ? qv_l : qv_m, 1'b1);
            chk($sformatf("%s_ql%0d", tag, i), lsb ? ql_l : ql_m, (i == n - 1));
            tick();
        end
        chk({tag, "_idle_qv"},   lsb ? qv_l   : qv_m,   1'b0);
        chk({tag, "_idle_busy"}, lsb ? busy_l : busy_m, 1'b0);
        chk({tag, "_idle_rdy"},  lsb ? rdy_l  : rdy_m,  1'b1);
    endtask

    initial begin
        logic [9:0]  stall_exp;
        logic [15:0] b2b_exp;

        CDN = 1'b0; PD = 8'h00; LD_VALID = 1'b0; EN = 1'b0;
        #2;
        chk("rst_q",    q_m,    1'b0);
        chk("rst_qv",   qv_m,   1'b0);
        chk("rst_ql",   ql_m,   1'b0);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_rdy",  rdy_m,  1'b1);
        #10;
        CDN = 1'b1;
        tick();
        EN = 1'b1;
        tick();
        chk("idle_en_qv", qv_m, 1'b0);

        // MSB-first A5
        PD = 8'hA5; LD_VALID = 1'b1;
        tick();
        LD_VALID = 1'b0; PD = 8'h00;
        play("a5", 16'h00A5, 8, 1'b0);

        // LSB-first 01
        PD = 8'h01; LD_VALID = 1'b1;
        tick();
        LD_VALID = 1'b0;
        play("lsb01", 16'h0080, 8, 1'b1);

        // Back-to-back FF then 00
        PD = 8'hFF; LD_VALID = 1'b1;
        tick();
        PD = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) LD_VALID = 1'b0;
            chk($sformatf("b2b_q%0d", i),  q_m,  (i < 8));
            chk($sformatf("b2b_qv%0d", i), qv_m, 1'b1);
            chk($sformatf("b2b_ql%0d", i), ql_m, (i == 7) || (i == 15));
            if (i == 3) chk("b2b_rdy_mid", rdy_m, 1'b0);
            if (i == 7) chk("b2b_rdy_last", rdy_m, 1'b1);
            tick();
        end
        chk("b2b_idle_qv", qv_m, 1'b0);

        // Stall during frame cycles 3 and 4
        stall_exp = 10'b10_1110_0101;
        PD = 8'hA5; LD_VALID = 1'b1;
        tick();
        LD_VALID = 1'b0;
        for (int i = 0; i < 10; i++) begin
            EN = !(i == 2 || i == 3);
            chk($sformatf("stall_q%0d", i),  q_m,  stall_exp[9-i]);
            chk($sformatf("stall_qv%0d", i), qv_m, 1'b1);
            chk($sformatf("stall_ql%0d", i), ql_m, (i == 9));
            if (i == 2) chk("stall_rdy", rdy_m, 1'b0);
            tick();
        end
        EN = 1'b1;
        chk("stall_idle_qv", qv_m, 1'b0);

        // Load request during bit 4 is held off until Q_LAST
        b2b_exp = 16'hA53C;
        PD = 8'hA5; LD_VALID = 1'b1;
        tick();
        LD_VALID = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin PD = 8'h3C; LD_VALID = 1'b1; end
            if (i == 8) begin LD_VALID = 1'b0; PD = 8'h00; end
            chk($sformatf("ign_q%0d", i),  q_m,  b2b_exp[15-i]);
            chk($sformatf("ign_qv%0d", i), qv_m, 1'b1);
            chk($sformatf("ign_ql%0d", i), ql_m, (i == 7) || (i == 15));
            tick();
        end
        chk("ign_idle_qv", qv_m, 1'b0);

        // Mid-frame asynchronous reset
        PD = 8'hA5; LD_VALID = 1'b1;
        tick();
        LD_VALID = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("mrst_busy_before", busy_m, 1'b1);
        #2;
        CDN = 1'b0;
        #1;
        chk("mrst_qv",   qv_m,   1'b0);
        chk("mrst_q",    q_m,    1'b0);
        chk("mrst_busy", busy_m, 1'b0);
        chk("mrst_rdy",  rdy_m,  1'b1);
        CDN = 1'b1;
        PD = 8'h0F; LD_VALID = 1'b1;
        tick();
        LD_VALID = 1'b0;
        play("post0f", 16'h000F, 8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
